// File: rtl/display_scanout_if.sv
// Scan-out bus: framebuffer and palette read ports plus the VGA-side outputs.
// The master is the scan-out engine; the slave is the memory/monitor side.
interface display_scanout_if #(
  parameter int FB_AW      = 17,
  parameter int PAL_AW     = 8,
  parameter int COLOR_BITS = 12
);
  logic [FB_AW-1:0]        fb_rd_index;
  logic [PAL_AW-1:0]       fb_rd_value;
  logic [PAL_AW-1:0]       palette_rd_index;
  logic [COLOR_BITS-1:0]   palette_rd_color;
  logic [COLOR_BITS/3-1:0] vga_r;
  logic [COLOR_BITS/3-1:0] vga_g;
  logic [COLOR_BITS/3-1:0] vga_b;
  logic                    vga_hs;
  logic                    vga_vs;
  logic                    vblank;
  logic                    frame_start;

  modport master (
    output fb_rd_index, palette_rd_index, vga_r, vga_g, vga_b,
           vga_hs, vga_vs, vblank, frame_start,
    input  fb_rd_value, palette_rd_color
  );

  modport slave (
    input  fb_rd_index, palette_rd_index, vga_r, vga_g, vga_b,
           vga_hs, vga_vs, vblank, frame_start,
    output fb_rd_value, palette_rd_color
  );
endinterface

// File: rtl/display_scanout.sv
// VGA scan-out: timing counters, multiplier-free framebuffer addressing with
// SCALE-fold pixel/line replication, palette lookup and a 3-cycle output pipeline.
module display_scanout #(
  parameter int RESOLUTION_X   = 400,
  parameter int RESOLUTION_Y   = 300,
  parameter int SCALE          = 2,
  parameter int PALETTE_LENGTH = 256,
  parameter int COLOR_BITS     = 12,
  parameter int H_ACTIVE       = 800,
  parameter int H_FP           = 40,
  parameter int H_SYNC         = 128,
  parameter int H_BP           = 88,
  parameter int V_ACTIVE       = 600,
  parameter int V_FP           = 1,
  parameter int V_SYNC         = 4,
  parameter int V_BP           = 23,
  parameter bit SYNC_POL       = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  display_scanout_if.master bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FB_AW   = $clog2(RESOLUTION_X * RESOLUTION_Y);
  localparam int PAL_AW  = $clog2(PALETTE_LENGTH);
  localparam int CH      = COLOR_BITS / 3;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int SW      = (SCALE > 1) ? $clog2(SCALE) : 1;

  if (H_ACTIVE != RESOLUTION_X * SCALE || V_ACTIVE != RESOLUTION_Y * SCALE ||
      COLOR_BITS % 3 != 0) begin : g_param_check
    $error("display_scanout: active area must equal RESOLUTION*SCALE and COLOR_BITS must be a multiple of 3");
  end

  // The first clock after reset release only arms the engine, so the
  // counters sit at (0,0) with frame_start high in the following cycle.
  typedef enum logic {ST_IDLE, ST_RUN} state_e;

  state_e              state_q, state_d;
  logic [HW-1:0]       h_q, h_d;
  logic [VW-1:0]       v_q, v_d;
  logic [FB_AW-1:0]    line_base_q, line_base_d;
  logic [FB_AW-1:0]    addr_q, addr_d;
  logic [SW-1:0]       sub_x_q, sub_x_d;
  logic [SW-1:0]       sub_y_q, sub_y_d;
  logic [1:0]          act_pipe_q, act_pipe_d;
  logic [2:0]          hs_pipe_q, hs_pipe_d;
  logic [2:0]          vs_pipe_q, vs_pipe_d;
  logic [CH-1:0]       r_q, r_d, g_q, g_d, b_q, b_d;
  logic                vblank_q, vblank_d;
  logic                frame_start_q, frame_start_d;

  logic                running, h_wrap, v_wrap, active_now, hs_level, vs_level;
  logic [PAL_AW-1:0]   pix_index;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    running    = (state_q == ST_RUN);
    h_wrap     = (h_q == HW'(H_TOTAL - 1));
    v_wrap     = (v_q == VW'(V_TOTAL - 1));
    active_now = running && (h_q < HW'(H_ACTIVE)) && (v_q < VW'(V_ACTIVE));

    state_d = ST_RUN;
    h_d     = h_q;
    v_d     = v_q;
    if (running) begin
      h_d = h_wrap ? '0 : h_q + 1'b1;
      if (h_wrap) v_d = v_wrap ? '0 : v_q + 1'b1;
    end

    line_base_d = line_base_q;
    addr_d      = addr_q;
    sub_x_d     = sub_x_q;
    sub_y_d     = sub_y_q;
    if (active_now) begin
      if (h_q == HW'(H_ACTIVE - 1)) begin
        // Row end: pick the base of the next line; after the last active
        // line it returns to 0 so the address never leaves the framebuffer.
        sub_x_d = '0;
        if (v_q == VW'(V_ACTIVE - 1)) begin
          line_base_d = '0;
          sub_y_d     = '0;
        end else if (sub_y_q == SW'(SCALE - 1)) begin
          line_base_d = line_base_q + FB_AW'(RESOLUTION_X);
          sub_y_d     = '0;
        end else begin
          sub_y_d = sub_y_q + 1'b1;
        end
        addr_d = line_base_d;
      end else if (sub_x_q == SW'(SCALE - 1)) begin
        sub_x_d = '0;
        addr_d  = addr_q + 1'b1;
      end else begin
        sub_x_d = sub_x_q + 1'b1;
      end
    end else if (running && h_wrap && v_wrap) begin
      line_base_d = '0;
      sub_y_d     = '0;
      sub_x_d     = '0;
      addr_d      = '0;
    end else begin
      sub_x_d = '0;
      addr_d  = line_base_q;
    end

    hs_level = (running && h_q >= HW'(H_ACTIVE + H_FP) &&
                h_q <= HW'(H_ACTIVE + H_FP + H_SYNC - 1)) ? SYNC_POL : ~SYNC_POL;
    vs_level = (running && v_q >= VW'(V_ACTIVE + V_FP) &&
                v_q <= VW'(V_ACTIVE + V_FP + V_SYNC - 1)) ? SYNC_POL : ~SYNC_POL;

    // The RGB register is the third delay stage of active, hence two here.
    act_pipe_d = {act_pipe_q[0], active_now};
    hs_pipe_d  = {hs_pipe_q[1:0], hs_level};
    vs_pipe_d  = {vs_pipe_q[1:0], vs_level};

    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (act_pipe_q[1]) begin
      r_d = bus.palette_rd_color[COLOR_BITS-1 -: CH];
      g_d = bus.palette_rd_color[2*CH-1 -: CH];
      b_d = bus.palette_rd_color[CH-1:0];
    end

    vblank_d      = (v_d >= VW'(V_ACTIVE));
    frame_start_d = (h_d == '0) && (v_d == '0);
  end

  // NOTE: sequential state uses non-blocking assignments only, and every flop
  // has an asynchronous reset so a mid-frame reset flushes the whole pipeline.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      h_q           <= '0;
      v_q           <= '0;
      line_base_q   <= '0;
      addr_q        <= '0;
      sub_x_q       <= '0;
      sub_y_q       <= '0;
      act_pipe_q    <= '0;
      hs_pipe_q     <= {3{~SYNC_POL}};
      vs_pipe_q     <= {3{~SYNC_POL}};
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
      vblank_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_q           <= h_d;
      v_q           <= v_d;
      line_base_q   <= line_base_d;
      addr_q        <= addr_d;
      sub_x_q       <= sub_x_d;
      sub_y_q       <= sub_y_d;
      act_pipe_q    <= act_pipe_d;
      hs_pipe_q     <= hs_pipe_d;
      vs_pipe_q     <= vs_pipe_d;
      r_q           <= r_d;
      g_q           <= g_d;
      b_q           <= b_d;
      vblank_q      <= vblank_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Palette address is the framebuffer value passed straight through.
  assign pix_index            = bus.fb_rd_value;
  assign bus.palette_rd_index = pix_index;
  assign bus.fb_rd_index      = addr_q;
  assign bus.vga_r            = r_q;
  assign bus.vga_g            = g_q;
  assign bus.vga_b            = b_q;
  assign bus.vga_hs           = hs_pipe_q[2];
  assign bus.vga_vs           = vs_pipe_q[2];
  assign bus.vblank           = vblank_q;
  assign bus.frame_start      = frame_start_q;
endmodule

// File: tb/tb_display_scanout.sv
// Bench for display_scanout: a reduced-geometry instance checked cycle by cycle
// against an arithmetic model, plus a full 800x600 instance for address/sync anchors.
module tb_display_scanout;
  localparam int S_RX = 8, S_RY = 6, S_SC = 2;
  localparam int S_HA = 16, S_HFP = 2, S_HSY = 3, S_HBP = 3;
  localparam int S_VA = 12, S_VFP = 1, S_VSY = 2, S_VBP = 2;
  localparam int S_HT = S_HA + S_HFP + S_HSY + S_HBP;
  localparam int S_VT = S_VA + S_VFP + S_VSY + S_VBP;
  localparam int S_FRAME = S_HT * S_VT;
  localparam int S_AW = $clog2(S_RX * S_RY);
  localparam int F_RX = 400, F_SC = 2, F_HA = 800, F_VA = 600;
  localparam int F_HT = 1056, F_VT = 628;
  localparam int F_AW = $clog2(400 * 300);

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pal_mode = 0;
  logic [7:0]  fb_mem  [S_RX*S_RY];
  logic [11:0] pal_mem [256];

  display_scanout_if #(.FB_AW(S_AW), .PAL_AW(8), .COLOR_BITS(12)) sbus ();
  display_scanout_if #(.FB_AW(F_AW), .PAL_AW(8), .COLOR_BITS(12)) fbus ();

  display_scanout #(
    .RESOLUTION_X(S_RX), .RESOLUTION_Y(S_RY), .SCALE(S_SC), .PALETTE_LENGTH(256),
    .COLOR_BITS(12), .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HSY), .H_BP(S_HBP),
    .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VSY), .V_BP(S_VBP), .SYNC_POL(1'b1)
  ) dut (.clk(clk), .reset_n(reset_n), .bus(sbus));

  display_scanout dut_full (.clk(clk), .reset_n(reset_n), .bus(fbus));

  function automatic logic [11:0] ident_color(input logic [7:0] idx);
    return {idx[3:0], idx[7:4], idx[3:0]};
  endfunction

  function automatic logic [11:0] small_palette(input logic [7:0] idx);
    case (pal_mode)
      0:       return ident_color(idx);
      1:       return 12'hFFF;
      default: return pal_mem[idx];
    endcase
  endfunction

  // Synchronous-read memories: data valid one cycle after the address.
  always @(posedge clk) begin
    sbus.fb_rd_value      <= (sbus.fb_rd_index < S_AW'(S_RX*S_RY)) ? fb_mem[sbus.fb_rd_index] : 8'hA5;
    sbus.palette_rd_color <= small_palette(sbus.palette_rd_index);
    fbus.fb_rd_value      <= fbus.fb_rd_index[7:0];
    fbus.palette_rd_color <= ident_color(fbus.palette_rd_index);
  end

  // Reference model: n counts cycles from the first frame_start after reset.
  function automatic int exp_addr(input int n, input int rx, input int sc, input int ha,
                                  input int va, input int ht, input int vt);
    int h, v, line;
    h = n % ht;
    v = (n / ht) % vt;
    line = (h >= ha) ? v + 1 : v;
    if (v < va && h < ha) return (v / sc) * rx + h / sc;
    if (line < va) return (line / sc) * rx;
    return 0;
  endfunction

  function automatic bit s_active(input int n);
    return ((n % S_HT) < S_HA) && (((n / S_HT) % S_VT) < S_VA);
  endfunction

  function automatic logic [11:0] exp_rgb_s(input int n);
    if (n < 3 || !s_active(n - 3)) return 12'h000;
    return small_palette(fb_mem[exp_addr(n - 3, S_RX, S_SC, S_HA, S_VA, S_HT, S_VT)]);
  endfunction

  function automatic logic exp_hs_s(input int n);
    int h;
    if (n < 3) return 1'b0;
    h = (n - 3) % S_HT;
    return (h >= S_HA + S_HFP) && (h < S_HA + S_HFP + S_HSY);
  endfunction

  function automatic logic exp_vs_s(input int n);
    int v;
    if (n < 3) return 1'b0;
    v = ((n - 3) / S_HT) % S_VT;
    return (v >= S_VA + S_VFP) && (v < S_VA + S_VFP + S_VSY);
  endfunction

  // Leaves reset_n released between edges; the next posedge arms the DUT.
  task automatic do_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    pal_mode = 1;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({sbus.vga_r, sbus.vga_g, sbus.vga_b} !== 12'h000) begin errors++; $display("FAIL reset_rgb got %h want 000", {sbus.vga_r, sbus.vga_g, sbus.vga_b}); end
    checks++; if ({sbus.vga_hs, sbus.vga_vs} !== 2'b00) begin errors++; $display("FAIL reset_sync got %b want 00", {sbus.vga_hs, sbus.vga_vs}); end
    checks++; if ({sbus.vblank, sbus.frame_start} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {sbus.vblank, sbus.frame_start}); end
    repeat (3) @(negedge clk);
    checks++; if (sbus.fb_rd_index !== '0) begin errors++; $display("FAIL reset_addr got %0d want 0", sbus.fb_rd_index); end
    #2 reset_n = 1'b1;
    @(posedge clk);
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      checks++; if (sbus.frame_start !== (n == 0)) begin errors++; $display("FAIL post_reset_fs n=%0d got %b want %b", n, sbus.frame_start, n == 0); end
      checks++; if ({sbus.vga_r, sbus.vga_g, sbus.vga_b} !== ((n < 3) ? 12'h000 : 12'hFFF)) begin errors++; $display("FAIL post_reset_rgb n=%0d got %h", n, {sbus.vga_r, sbus.vga_g, sbus.vga_b}); end
      checks++; if (sbus.fb_rd_index !== S_AW'(n / 2)) begin errors++; $display("FAIL post_reset_addr n=%0d got %0d want %0d", n, sbus.fb_rd_index, n / 2); end
    end
  endtask

  task automatic test_full_address();
    int exp_h;
    do_reset();
    @(posedge clk);
    for (int n = 0; n < 3 * F_HT + 8; n++) begin
      @(negedge clk);
      checks++; if (fbus.fb_rd_index !== F_AW'(exp_addr(n, F_RX, F_SC, F_HA, F_VA, F_HT, F_VT))) begin errors++; $display("FAIL full_addr n=%0d got %0d want %0d", n, fbus.fb_rd_index, exp_addr(n, F_RX, F_SC, F_HA, F_VA, F_HT, F_VT)); end
      if (n == 2 || n == 799 || n == 2 * F_HT) begin
        exp_h = (n == 2) ? 1 : (n == 799) ? 399 : 400;
        checks++; if (fbus.fb_rd_index !== F_AW'(exp_h)) begin errors++; $display("FAIL full_anchor n=%0d got %0d want %0d", n, fbus.fb_rd_index, exp_h); end
      end
      if (n == 4 || n == 5) begin
        checks++; if ({fbus.vga_r, fbus.vga_g, fbus.vga_b} !== ((n == 5) ? 12'h101 : 12'h000)) begin errors++; $display("FAIL full_latency n=%0d got %h", n, {fbus.vga_r, fbus.vga_g, fbus.vga_b}); end
      end
      exp_h = (n >= 3 && ((n - 3) % F_HT) >= 840 && ((n - 3) % F_HT) <= 967) ? 1 : 0;
      checks++; if (fbus.vga_hs !== exp_h[0]) begin errors++; $display("FAIL full_hs n=%0d got %b want %0d", n, fbus.vga_hs, exp_h); end
    end
  endtask

  task automatic test_random_frames();
    int a;
    for (int i = 0; i < S_RX * S_RY; i++) fb_mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) pal_mem[i] = 12'($urandom);
    pal_mode = 2;
    do_reset();
    @(posedge clk);
    for (int n = 0; n < 3 * S_FRAME + 20; n++) begin
      @(negedge clk);
      a = exp_addr(n, S_RX, S_SC, S_HA, S_VA, S_HT, S_VT);
      checks++; if (sbus.fb_rd_index !== S_AW'(a)) begin errors++; $display("FAIL rand_addr n=%0d got %0d want %0d", n, sbus.fb_rd_index, a); end
      checks++; if ({sbus.vga_r, sbus.vga_g, sbus.vga_b} !== exp_rgb_s(n)) begin errors++; $display("FAIL rand_rgb n=%0d got %h want %h", n, {sbus.vga_r, sbus.vga_g, sbus.vga_b}, exp_rgb_s(n)); end
      checks++; if (sbus.vga_hs !== exp_hs_s(n)) begin errors++; $display("FAIL rand_hs n=%0d got %b want %b", n, sbus.vga_hs, exp_hs_s(n)); end
      checks++; if (sbus.vga_vs !== exp_vs_s(n)) begin errors++; $display("FAIL rand_vs n=%0d got %b want %b", n, sbus.vga_vs, exp_vs_s(n)); end
      checks++; if (sbus.vblank !== (((n / S_HT) % S_VT) >= S_VA)) begin errors++; $display("FAIL rand_vblank n=%0d got %b", n, sbus.vblank); end
      checks++; if (sbus.frame_start !== ((n % S_FRAME) == 0)) begin errors++; $display("FAIL rand_frame_start n=%0d got %b", n, sbus.frame_start); end
    end
  endtask

  task automatic test_blanking();
    logic [11:0] want;
    pal_mode = 1;
    do_reset();
    @(posedge clk);
    for (int n = 0; n < S_FRAME + 4; n++) begin
      @(negedge clk);
      want = (n >= 3 && s_active(n - 3)) ? 12'hFFF : 12'h000;
      checks++; if ({sbus.vga_r, sbus.vga_g, sbus.vga_b} !== want) begin errors++; $display("FAIL blank_rgb n=%0d got %h want %h", n, {sbus.vga_r, sbus.vga_g, sbus.vga_b}, want); end
    end
  endtask

  task automatic test_frame_period();
    int cnt, rise_at;
    do_reset();
    @(posedge clk);
    @(negedge clk);
    checks++; if (sbus.frame_start !== 1'b1) begin errors++; $display("FAIL period_first_fs got %b want 1", sbus.frame_start); end
    for (int f = 0; f < 3; f++) begin
      cnt = 0;
      rise_at = -1;
      do begin
        @(negedge clk);
        cnt++;
        if (rise_at < 0 && sbus.vblank === 1'b1) rise_at = cnt;
      end while (sbus.frame_start !== 1'b1 && cnt < 2 * S_FRAME);
      checks++; if (cnt != S_FRAME) begin errors++; $display("FAIL frame_period f=%0d got %0d want %0d", f, cnt, S_FRAME); end
      checks++; if (rise_at != S_VA * S_HT) begin errors++; $display("FAIL vblank_rise f=%0d got %0d want %0d", f, rise_at, S_VA * S_HT); end
      checks++; if (sbus.vblank !== 1'b0) begin errors++; $display("FAIL vblank_fall f=%0d got %b want 0", f, sbus.vblank); end
    end
  endtask

  task automatic test_midframe_reset();
    pal_mode = 1;
    do_reset();
    @(posedge clk);
    for (int n = 0; n <= 6 * S_HT + 8; n++) @(negedge clk);
    checks++; if ({sbus.vga_r, sbus.vga_g, sbus.vga_b} !== 12'hFFF) begin errors++; $display("FAIL mid_pre_rgb got %h want fff", {sbus.vga_r, sbus.vga_g, sbus.vga_b}); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({sbus.vga_r, sbus.vga_g, sbus.vga_b} !== 12'h000) begin errors++; $display("FAIL mid_rgb got %h want 000", {sbus.vga_r, sbus.vga_g, sbus.vga_b}); end
    checks++; if ({sbus.vga_hs, sbus.vga_vs, sbus.vblank} !== 3'b000) begin errors++; $display("FAIL mid_sync got %b want 000", {sbus.vga_hs, sbus.vga_vs, sbus.vblank}); end
    checks++; if (sbus.fb_rd_index !== '0) begin errors++; $display("FAIL mid_addr got %0d want 0", sbus.fb_rd_index); end
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      checks++; if (sbus.frame_start !== (n == 0)) begin errors++; $display("FAIL mid_fs n=%0d got %b", n, sbus.frame_start); end
      checks++; if (sbus.fb_rd_index !== S_AW'(exp_addr(n, S_RX, S_SC, S_HA, S_VA, S_HT, S_VT))) begin errors++; $display("FAIL mid_restart_addr n=%0d got %0d", n, sbus.fb_rd_index); end
      checks++; if ({sbus.vga_r, sbus.vga_g, sbus.vga_b} !== exp_rgb_s(n)) begin errors++; $display("FAIL mid_restart_rgb n=%0d got %h want %h", n, {sbus.vga_r, sbus.vga_g, sbus.vga_b}, exp_rgb_s(n)); end
    end
  endtask

  initial begin
    for (int i = 0; i < S_RX * S_RY; i++) fb_mem[i] = 8'(i * 37 + 5);
    for (int i = 0; i < 256; i++) pal_mem[i] = 12'(i);
    test_reset();
    test_full_address();
    test_random_frames();
    test_blanking();
    test_frame_period();
    test_midframe_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
